// File: rtl/lc3b_types.sv
// Shared types for the L2 cache controller: controller state encoding and
// the default width of the performance counters.
package lc3b_types;

    localparam int L2_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TAG_CHECK = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } l2_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts enabled cycles and holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Increment only while below the all-ones ceiling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/l2_cache_control.sv
// L2 cache controller: sequences tag check, dirty-victim writeback and line
// allocation, and keeps first-look hit/miss performance counters.
module l2_cache_control
    import lc3b_types::*;
#(
    parameter int CNT_WIDTH = L2_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    input  logic                 hit0,
    input  logic                 hit1,
    input  logic                 lru,
    input  logic                 victim_valid,
    input  logic                 victim_dirty,
    input  logic                 pmem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic                 way_sel,
    output logic                 load_way,
    output logic                 data_src,
    output logic                 dirty_in,
    output logic                 load_lru,
    output logic                 lru_in,
    output logic                 pmem_addr_sel,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    l2_state_t state_r;
    l2_state_t next_state_s;
    logic      retry_r;
    logic      hit_s;
    logic      hit_way_s;
    logic      is_write_s;
    logic      hit_inc_s;
    logic      miss_inc_s;

    // Next state, datapath controls and counter enables.
    always_comb begin
        next_state_s  = state_r;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        way_sel       = 1'b0;
        load_way      = 1'b0;
        data_src      = 1'b0;
        dirty_in      = 1'b0;
        load_lru      = 1'b0;
        lru_in        = 1'b0;
        pmem_addr_sel = 1'b0;
        hit_s         = hit0 | hit1;
        // Way 0 wins when both ways report a match; a simultaneous read and write is a read.
        hit_way_s     = ~hit0;
        is_write_s    = mem_write & ~mem_read;
        hit_inc_s     = (state_r == TAG_CHECK) && hit_s && !retry_r;
        miss_inc_s    = (state_r == TAG_CHECK) && !hit_s && !retry_r;
        case (state_r)
            IDLE: begin
                if (mem_read || mem_write) begin
                    next_state_s = TAG_CHECK;
                end else begin
                    next_state_s = IDLE;
                end
            end
            TAG_CHECK: begin
                if (hit_s) begin
                    mem_resp     = 1'b1;
                    load_lru     = 1'b1;
                    lru_in       = ~hit_way_s;
                    next_state_s = IDLE;
                    if (is_write_s) begin
                        load_way = 1'b1;
                        way_sel  = hit_way_s;
                        data_src = 1'b1;
                        dirty_in = 1'b1;
                    end else begin
                        load_way = 1'b0;
                    end
                end else if (victim_valid && victim_dirty) begin
                    next_state_s = WRITEBACK;
                end else begin
                    next_state_s = ALLOCATE;
                end
            end
            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                way_sel       = lru;
                if (pmem_resp) begin
                    next_state_s = ALLOCATE;
                end else begin
                    next_state_s = WRITEBACK;
                end
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                way_sel   = lru;
                if (pmem_resp) begin
                    load_way     = 1'b1;
                    next_state_s = TAG_CHECK;
                end else begin
                    next_state_s = ALLOCATE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register; retry marks the post-fill tag check so a request counts once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            retry_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if ((state_r == ALLOCATE) && pmem_resp) begin
                retry_r <= 1'b1;
            end else if (state_r == IDLE) begin
                retry_r <= 1'b0;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_inc_s),
        .count (hit_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_inc_s),
        .count (miss_count)
    );

endmodule
